// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and load/store requesters onto one unified memory port,
// with data priority, a fetch-starvation guard and read-modify-write for sub-word stores.
module mem_port_arbiter #(
  parameter logic [31:0] START_ADDR   = 32'h0100_0000,
  parameter int unsigned MEM_SIZE     = 1048576,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_w_enable,
  input  logic [31:0] mem_data_out
);

  localparam int unsigned CW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  localparam logic [CW-1:0] LIMIT     = CW'(STARVE_LIMIT);
  localparam logic [32:0]   LAST_ADDR = {1'b0, START_ADDR} + 33'(MEM_SIZE) - 33'd1;

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          own_d_q, own_d_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          bad_q, bad_d;
  logic          if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic          if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic          if_err_q, if_err_d, d_err_q, d_err_d;
  logic [31:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;

  logic          data_win;
  logic [31:0]   req_addr;
  logic          addr_ok;
  logic [31:0]   merged;

  assign data_win = d_req && (!if_req || (starve_q < LIMIT));
  assign req_addr = data_win ? d_addr : if_addr;
  // 33-bit compare so an address near 2^32 cannot wrap into the legal window
  assign addr_ok  = ({1'b0, req_addr} >= {1'b0, START_ADDR}) &&
                    (({1'b0, req_addr} + 33'd3) <= LAST_ADDR);
  assign merged   = (size_q == 2'd0) ? {mem_data_out[31:8], wdata_q[7:0]}
                                     : {mem_data_out[31:16], wdata_q[15:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      own_d_q     <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= '0;
      wdata_q     <= '0;
      bad_q       <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_addr_q  <= START_ADDR;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      own_d_q     <= own_d_d;
      we_q        <= we_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      bad_q       <= bad_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_err_q    <= if_err_d;
      d_err_q     <= d_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    own_d_d     = own_d_q;
    we_d        = we_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    bad_d       = bad_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_err_d    = 1'b0;
    d_err_d     = 1'b0;
    mem_we_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!if_req || !data_win) begin
          starve_d = '0;
        end else if (starve_q < LIMIT) begin
          starve_d = starve_q + CW'(1);
        end
        if (if_req || d_req) begin
          state_d    = ACCESS;
          own_d_d    = data_win;
          we_d       = data_win && d_we;
          size_d     = d_size;
          wdata_d    = d_wdata[15:0];
          bad_d      = !addr_ok;
          mem_addr_d = req_addr;
          if_gnt_d   = !data_win;
          d_gnt_d    = data_win;
          if (data_win && d_we && d_size[1] && addr_ok) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = d_wdata;
          end
        end
      end
      ACCESS: begin
        // Illegal requests also pass through here (no memory action) so every
        // non-merging response lands two cycles after arbitration.
        if (!bad_q && we_q && !size_q[1]) begin
          state_d     = MERGE;
          mem_we_d    = 1'b1;
          mem_wdata_d = merged;
        end else begin
          state_d = RESP;
          if (own_d_q) begin
            d_rvalid_d = 1'b1;
            d_err_d    = bad_q;
            d_rdata_d  = (bad_q || we_q) ? '0 : mem_data_out;
          end else begin
            if_rvalid_d = 1'b1;
            if_err_d    = bad_q;
            if_rdata_d  = bad_q ? '0 : mem_data_out;
          end
        end
      end
      MERGE: begin
        state_d    = RESP;
        d_rvalid_d = 1'b1;
        d_rdata_d  = '0;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign if_gnt       = if_gnt_q;
  assign if_rvalid    = if_rvalid_q;
  assign if_rdata     = if_rdata_q;
  assign if_err       = if_err_q;
  assign d_gnt        = d_gnt_q;
  assign d_rvalid     = d_rvalid_q;
  assign d_rdata      = d_rdata_q;
  assign d_err        = d_err_q;
  assign mem_address  = mem_addr_q;
  assign mem_data_in  = mem_wdata_q;
  assign mem_w_enable = mem_we_q;

endmodule
